// File: rtl/dpll_loop_controller.sv
// ---------------------------------------------------------------------------
// dpll_loop_controller
// Sequencing controller for the digital PLL loop: pulses the phase detector
// reset, synchronizes and samples its dir output, and steps the DCO control
// word through coarse acquisition and fine tracking, reporting lock.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module dpll_loop_controller #(
  parameter int CW         = 8,
  parameter int CW_INIT    = 128,
  parameter int STEP_ACQ   = 8,
  parameter int STEP_TRK   = 1,
  parameter int UPD_INT    = 4,
  parameter int PD_RST_CYC = 4,
  parameter int LOCK_CNT   = 8,
  parameter int RELOCK_RUN = 4
) (
  input  logic          f_ref,
  input  logic          rst,
  input  logic          en,
  input  logic          dir,
  output logic          pd_rst,
  output logic [CW-1:0] ctrl,
  output logic          locked,
  output logic [1:0]    state
);

  localparam int UPD_W = (UPD_INT > 1) ? $clog2(UPD_INT) : 1;
  localparam int PD_W  = (PD_RST_CYC > 1) ? $clog2(PD_RST_CYC) : 1;
  localparam int LK_W  = $clog2(LOCK_CNT + 1);
  localparam int RN_W  = $clog2(RELOCK_RUN + 1);

  localparam logic [UPD_W-1:0] C_UPD_LAST = UPD_W'(UPD_INT - 1);
  localparam logic [PD_W-1:0]  C_PD_LAST  = PD_W'(PD_RST_CYC - 1);
  localparam logic [LK_W-1:0]  C_LOCK_MAX = LK_W'(LOCK_CNT);
  localparam logic [RN_W-1:0]  C_RUN_LAST = RN_W'(RELOCK_RUN - 1);
  localparam logic [CW-1:0]    C_INIT     = CW'(CW_INIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PD_INIT = 2'd1,
    S_ACQUIRE = 2'd2,
    S_TRACK   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    ctrl_q, ctrl_d;
  logic             pd_rst_q, pd_rst_d;
  logic             locked_q, locked_d;
  logic [PD_W-1:0]  pd_cnt_q, pd_cnt_d;
  logic [UPD_W-1:0] upd_cnt_q, upd_cnt_d;
  logic [LK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [RN_W-1:0]  run_cnt_q, run_cnt_d;
  logic             prev_dir_q, prev_dir_d;
  logic             prev_valid_q, prev_valid_d;
  logic             dir_meta_q, dir_s_q;

  logic             w_strobe;
  logic             w_rev;
  logic [CW-1:0]    w_step;
  logic [CW:0]      w_sum;
  logic [CW-1:0]    w_ctrl_stepped;

  // Two-flop synchronizer for the asynchronous phase detector output
  always_ff @(posedge f_ref or negedge rst) begin
    if (!rst) begin
      dir_meta_q <= 1'b0;
      dir_s_q    <= 1'b0;
    end else begin
      dir_meta_q <= dir;
      dir_s_q    <= dir_meta_q;
    end
  end

  // Saturating step of the control word in the direction of dir_s
  always_comb begin
    w_step         = (state_q == S_ACQUIRE) ? CW'(STEP_ACQ) : CW'(STEP_TRK);
    w_sum          = {1'b0, ctrl_q} + {1'b0, w_step};
    w_ctrl_stepped = ctrl_q;
    if (dir_s_q) begin
      w_ctrl_stepped = w_sum[CW] ? {CW{1'b1}} : w_sum[CW-1:0];
    end else begin
      w_ctrl_stepped = (ctrl_q < w_step) ? '0 : (ctrl_q - w_step);
    end
  end

  // Next-state logic: sequencing, update strobe, reversal and lock bookkeeping
  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    pd_rst_d     = pd_rst_q;
    locked_d     = locked_q;
    pd_cnt_d     = pd_cnt_q;
    upd_cnt_d    = upd_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    run_cnt_d    = run_cnt_q;
    prev_dir_d   = prev_dir_q;
    prev_valid_d = prev_valid_q;

    w_strobe = ((state_q == S_ACQUIRE) || (state_q == S_TRACK)) && (upd_cnt_q == C_UPD_LAST);
    w_rev    = prev_valid_q && (dir_s_q != prev_dir_q);

    case (state_q)
      S_IDLE: begin
        ctrl_d   = C_INIT;
        pd_rst_d = 1'b0;
        locked_d = 1'b0;
        if (en) begin
          state_d  = S_PD_INIT;
          pd_cnt_d = '0;
        end
      end

      S_PD_INIT: begin
        pd_rst_d = 1'b0;
        if (pd_cnt_q == C_PD_LAST) begin
          state_d      = S_ACQUIRE;
          pd_rst_d     = 1'b1;
          upd_cnt_d    = '0;
          prev_valid_d = 1'b0;
        end else begin
          pd_cnt_d = pd_cnt_q + PD_W'(1);
        end
      end

      S_ACQUIRE: begin
        upd_cnt_d = w_strobe ? '0 : (upd_cnt_q + UPD_W'(1));
        if (w_strobe) begin
          ctrl_d       = w_ctrl_stepped;
          prev_dir_d   = dir_s_q;
          prev_valid_d = 1'b1;
          if (w_rev) begin
            state_d    = S_TRACK;
            lock_cnt_d = '0;
            run_cnt_d  = '0;
          end
        end
      end

      S_TRACK: begin
        upd_cnt_d = w_strobe ? '0 : (upd_cnt_q + UPD_W'(1));
        // Lock is reported one cycle after the reversal count saturates and
        // then sticks for as long as we stay in tracking.
        if (lock_cnt_q == C_LOCK_MAX) begin
          locked_d = 1'b1;
        end
        if (w_strobe) begin
          ctrl_d       = w_ctrl_stepped;
          prev_dir_d   = dir_s_q;
          prev_valid_d = 1'b1;
          if (w_rev) begin
            lock_cnt_d = (lock_cnt_q == C_LOCK_MAX) ? lock_cnt_q : (lock_cnt_q + LK_W'(1));
            run_cnt_d  = '0;
          end else begin
            lock_cnt_d = '0;
            run_cnt_d  = run_cnt_q + RN_W'(1);
            // A long one-sided run means we slipped out of lock: go coarse.
            if (run_cnt_q == C_RUN_LAST) begin
              state_d      = S_ACQUIRE;
              locked_d     = 1'b0;
              upd_cnt_d    = '0;
              prev_valid_d = 1'b0;
              run_cnt_d    = '0;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Disable wins over everything, including a coincident update.
    if (!en) begin
      state_d      = S_IDLE;
      ctrl_d       = C_INIT;
      pd_rst_d     = 1'b0;
      locked_d     = 1'b0;
      pd_cnt_d     = '0;
      upd_cnt_d    = '0;
      lock_cnt_d   = '0;
      run_cnt_d    = '0;
      prev_dir_d   = 1'b0;
      prev_valid_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge f_ref or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ctrl_q       <= C_INIT;
      pd_rst_q     <= 1'b0;
      locked_q     <= 1'b0;
      pd_cnt_q     <= '0;
      upd_cnt_q    <= '0;
      lock_cnt_q   <= '0;
      run_cnt_q    <= '0;
      prev_dir_q   <= 1'b0;
      prev_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      pd_rst_q     <= pd_rst_d;
      locked_q     <= locked_d;
      pd_cnt_q     <= pd_cnt_d;
      upd_cnt_q    <= upd_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      run_cnt_q    <= run_cnt_d;
      prev_dir_q   <= prev_dir_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  assign pd_rst = pd_rst_q;
  assign ctrl   = ctrl_q;
  assign locked = locked_q;
  assign state  = state_q;

endmodule

`default_nettype wire

// File: doc/dpll_loop_controller.md
Name: dpll_loop_controller

Overview:
Sequencing controller for the digital PLL loop. It drives the phase detector reset, samples the detector's dir output, and steps the oscillator control word. It runs a coarse acquisition phase, then fine tracking, and asserts locked once the phase error has settled into alternation. It sits between the phase detector and the DCO/divider control input, clocked by the reference clock.

Parameters:
CW, 8, width of control word ctrl
CW_INIT, 128, ctrl value after reset, in IDLE, and on disable
STEP_ACQ, 8, ctrl step per update in ACQUIRE
STEP_TRK, 1, ctrl step per update in TRACK
UPD_INT, 4, f_ref cycles between ctrl updates (>=3)
PD_RST_CYC, 4, cycles pd_rst held low in PD_INIT (>=1)
LOCK_CNT, 8, consecutive TRACK reversals required to assert locked
RELOCK_RUN, 4, consecutive same-direction TRACK updates that force return to ACQUIRE

Ports:
f_ref  input  1  reference clock; all state on rising edge
rst  input  1  asynchronous active-low reset
en  input  1  loop enable, synchronous level
dir  input  1  phase detector output, asynchronous; 1 = reference leads (raise ctrl), 0 = lags (lower ctrl)
pd_rst  output  1  active-low reset to phase detector
ctrl  output  CW  oscillator control word
locked  output  1  lock indication
state  output  2  current FSM state (debug)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ctrl=CW_INIT, pd_rst=0, locked=0. All counters, prev_dir, prev_valid and both synchronizer flops are cleared. Release is synchronous to f_ref.
- dir passes through a 2-flop synchronizer to dir_s. It is never used unsynchronized.
- State encoding: IDLE=0, PD_INIT=1, ACQUIRE=2, TRACK=3.
- en=0 in any state: next cycle state=IDLE, ctrl=CW_INIT, pd_rst=0, locked=0, counters cleared. en=0 has priority over every other transition, including an update in the same cycle.
- IDLE: outputs held as at reset. en=1 moves to PD_INIT.
- PD_INIT: pd_rst=0 for exactly PD_RST_CYC cycles, counted from entry. Then pd_rst=1, upd_cnt=0, prev_valid=0, and the FSM enters ACQUIRE.
- Update strobe: in ACQUIRE/TRACK, upd_cnt counts 0..UPD_INT-1 and wraps. It fires when upd_cnt==UPD_INT-1, so the first update comes UPD_INT cycles after state entry. The ctrl change is visible the cycle after the strobe.
- Step rule: at each strobe, ctrl += step if dir_s=1, else ctrl -= step. Arithmetic is unsigned and saturating: clamp at 0 and 2^CW-1, never wrap. prev_dir<=dir_s and prev_valid<=1 at each strobe.
- ACQUIRE uses STEP_ACQ.
  - A strobe with prev_valid=1 and dir_s!=prev_dir is a reversal. It still applies its step, then enters TRACK with lock_cnt=0, run_cnt=0, upd_cnt=0.
  - prev_valid and prev_dir are kept across the transition.
- TRACK uses STEP_TRK.
  - Reversal strobe: lock_cnt++ (saturates at LOCK_CNT) and run_cnt=0.
  - Same-direction strobe: lock_cnt=0 and run_cnt++.
  - When run_cnt reaches RELOCK_RUN: the step for that strobe is still applied, then state=ACQUIRE, locked=0, upd_cnt=0, prev_valid=0.
- locked: set to 1 the cycle after lock_cnt reaches LOCK_CNT. Once set, it stays 1 in TRACK even if lock_cnt clears. It is cleared only on leaving TRACK (ACQUIRE, IDLE, or reset).
- Saturated ctrl with dir still pushing the same way: ctrl stays at the rail, and run_cnt/lock_cnt update normally.
- pd_rst stays 1 in ACQUIRE and TRACK. Returning to ACQUIRE from TRACK does not re-pulse pd_rst. Only IDLE->PD_INIT does.

Test Plan:
- Reset, then en=1 with dir=1 held, defaults: pd_rst low 4 cycles then high. state: 0->1->2. ctrl steps 128,136,144... every 4 cycles (first change ~4 cycles after ACQUIRE entry). locked=0.
- dir=1 for 3 ACQUIRE updates (ctrl=152), then dir=0: next update gives ctrl=144 and state=3. Subsequent updates step by 1.
- In TRACK, toggle dir every 4 cycles for 8 updates: ctrl oscillates ±1, locked rises after the 8th reversal. Four same-direction updates then: state=2, locked=0.
- CW_INIT=250 with dir=1 held: ctrl saturates at 255 and never wraps to 0. Mirror test with CW_INIT=3 and dir=0: ctrl clamps at 0.
- Drop en for one cycle mid-TRACK with locked=1: next cycle state=0, ctrl=128, pd_rst=0, locked=0. Re-enable: full PD_INIT pulse repeats.
- Assert rst asynchronously between clock edges while locked: outputs go to reset values immediately, without waiting for f_ref.
